arc4_encrypt: RTL
=================

Name: arc4_encrypt

Overview:
Encrypting counterpart to the ARC4 decrypt/crack path. Reads a length-prefixed plaintext message from a PT memory and runs init, KSA and PRGA on an external 256x8 S memory. Writes the length-prefixed ciphertext to a CT memory in the same format the decrypt path consumes. Sits beside the crack/decrypt cores and produces CT images that those cores can recover.

Parameters:
KEY_BYTES, 3, key length in bytes; key byte n = key[8*KEY_BYTES-1-8n -: 8], so the MSB byte is used first.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
en  input  1  start pulse; sampled only while rdy=1
rdy  output  1  high when idle and able to accept en
key  input  8*KEY_BYTES  encryption key; captured on the accepted en
pt_addr  output  8  PT memory read address
pt_rddata  input  8  PT read data; valid 1 cycle after pt_addr
ct_addr  output  8  CT memory write address
ct_wrdata  output  8  CT write data
ct_wren  output  1  CT write strobe, one cycle per byte
s_addr  output  8  S memory address
s_rddata  input  8  S read data; valid 1 cycle after s_addr
s_wrdata  output  8  S write data
s_wren  output  1  S write strobe

Behaviour:
- Reset: rdy=1; ct_wren=0; s_wren=0; all addresses and data outputs 0; FSM to IDLE; i, j, k and len cleared. Reset mid-operation aborts immediately; no further writes occur; rdy=1 on the cycle after rst deasserts.
- Handshake: en is accepted when rdy=1 and en=1 on the same edge; rdy drops on the next cycle. en while rdy=0 is ignored. rdy returns to 1 only after the last CT write. key is latched at acceptance; later key changes do not affect the run.
- Memory timing: registered address, unregistered output (altsyncram style). Read data is used exactly 1 cycle after the address is presented. Exactly one S access occurs per cycle; never read and write S in the same cycle.
- States: IDLE -> INIT -> KSA -> LEN -> PRGA -> DONE -> IDLE.
- INIT: for i=0..255, write S[i]=i. One write per cycle; 256 cycles.
- KSA: for i=0..255, j = j + S[i] + keybyte[i mod KEY_BYTES] (mod 256), then swap S[i] and S[j]. Sequence per i: read S[i], wait, read S[j], wait, write S[i]=S[j], write S[j]=old S[i]. i=j must leave S unchanged.
- LEN: read pt[0], then write ct[0]=pt[0] and latch len. If len=0, go directly to DONE.
- PRGA: i=j=0 at entry. For k=1..len:
  - i=i+1; read S[i]; j=j+S[i].
  - read S[j]; swap S[i] and S[j].
  - read S[(S[i]+S[j]) mod 256] -> pad.
  - read pt[k]; write ct[k]=pt[k]^pad. One ct_wren pulse per k.
- Arithmetic: all index sums are 8-bit wrap-around. k counts 1..255 with no overflow; len=255 writes ct[1..255].
- DONE: one cycle, then IDLE with rdy=1. S is left holding its post-PRGA contents.
- The algorithm is symmetric: feeding a CT image back as PT with the same key regenerates the plaintext.

Optional Feature:
ARC4_ENC_CYCLES_EN
- Defined: adds output port cycles[19:0]. It clears on accepted en, increments every cycle while rdy=0, and holds its final value while idle. Reset value 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- key=24'h4B6579 ("Key"), PT = 09,50 6C 61 69 6E 74 65 78 74 -> CT = 09,BB F3 16 E8 D9 40 AF 0A D3; rdy=1 afterwards; exactly 10 ct_wren pulses.
- Round trip: load the CT from the previous case as PT, same key -> CT memory holds 09,50 6C 61 69 6E 74 65 78 74.
- Zero length: PT[0]=00, any key -> only ct[0]=00 written (1 ct_wren); S holds the post-KSA state; rdy returns.
- Length 255 with key 24'h000001: compare all 256 CT bytes to a software ARC4 model; no write to any address beyond 255.
- Busy protection: pulse en and change key during KSA -> no restart; output matches the original key; only one rdy rise.
- Reset mid-PRGA: assert rst after ct[3] is written -> ct_wren and s_wren drop next cycle; rdy=1 after release. A fresh en with the Key/Plaintext vectors yields the correct CT.

Source files
------------

// File: rtl/arc4_encrypt.sv
// ============================================================================
// arc4_encrypt : ARC4 encryptor, PT memory -> CT memory via external S memory.
// Optional cycle counter port enabled by ARC4_ENC_CYCLES_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module arc4_encrypt #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [7:0]             ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren,
    output logic [7:0]             s_addr,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren
`ifdef ARC4_ENC_CYCLES_EN
    ,
    output logic [19:0]            cycles
`endif
);

    typedef enum logic [4:0] {
        ST_IDLE, ST_INIT,
        ST_KSA_RI, ST_KSA_WI, ST_KSA_RJ, ST_KSA_WJ, ST_KSA_SI, ST_KSA_SJ,
        ST_LEN_R, ST_LEN_W, ST_LEN_D,
        ST_PRGA_RI, ST_PRGA_WI, ST_PRGA_RJ, ST_PRGA_WJ, ST_PRGA_SI,
        ST_PRGA_SJ, ST_PRGA_RP, ST_PRGA_WP, ST_PRGA_CT,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
    logic [7:0]             si_q, si_d, sj_q, sj_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic [7:0]             pt_addr_q, pt_addr_d;
    logic [7:0]             ct_addr_q, ct_addr_d, ct_wrdata_q, ct_wrdata_d;
    logic                   ct_wren_q, ct_wren_d;
    logic [7:0]             s_addr_q, s_addr_d, s_wrdata_q, s_wrdata_d;
    logic                   s_wren_q, s_wren_d;

    logic [8*KEY_BYTES-1:0] w_key_rot;
    logic [7:0]             w_key_byte;
    logic [7:0]             w_ksa_j;
    logic [7:0]             w_prga_j;

    // The key register rotates one byte per KSA step, so its top byte is always keybyte[i mod KEY_BYTES].
    generate
        if (KEY_BYTES > 1) begin : g_rot_multi
            assign w_key_rot = {key_q[8*KEY_BYTES-9:0], key_q[8*KEY_BYTES-1 -: 8]};
        end else begin : g_rot_single
            assign w_key_rot = key_q;
        end
    endgenerate

    assign w_key_byte = key_q[8*KEY_BYTES-1 -: 8];
    assign w_ksa_j    = j_q + s_rddata + w_key_byte;
    assign w_prga_j   = j_q + s_rddata;

    assign rdy       = (state_q == ST_IDLE);
    assign pt_addr   = pt_addr_q;
    assign ct_addr   = ct_addr_q;
    assign ct_wrdata = ct_wrdata_q;
    assign ct_wren   = ct_wren_q;
    assign s_addr    = s_addr_q;
    assign s_wrdata  = s_wrdata_q;
    assign s_wren    = s_wren_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            k_q         <= 8'd0;
            len_q       <= 8'd0;
            si_q        <= 8'd0;
            sj_q        <= 8'd0;
            key_q       <= '0;
            pt_addr_q   <= 8'd0;
            ct_addr_q   <= 8'd0;
            ct_wrdata_q <= 8'd0;
            ct_wren_q   <= 1'b0;
            s_addr_q    <= 8'd0;
            s_wrdata_q  <= 8'd0;
            s_wren_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            len_q       <= len_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            key_q       <= key_d;
            pt_addr_q   <= pt_addr_d;
            ct_addr_q   <= ct_addr_d;
            ct_wrdata_q <= ct_wrdata_d;
            ct_wren_q   <= ct_wren_d;
            s_addr_q    <= s_addr_d;
            s_wrdata_q  <= s_wrdata_d;
            s_wren_q    <= s_wren_d;
        end
    end

    // Each state decides the memory access presented during the following cycle.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        len_d       = len_q;
        si_d        = si_q;
        sj_d        = sj_q;
        key_d       = key_q;
        pt_addr_d   = pt_addr_q;
        ct_addr_d   = ct_addr_q;
        ct_wrdata_d = ct_wrdata_q;
        ct_wren_d   = 1'b0;
        s_addr_d    = s_addr_q;
        s_wrdata_d  = s_wrdata_q;
        s_wren_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    key_d      = key;
                    i_d        = 8'd0;
                    j_d        = 8'd0;
                    k_d        = 8'd0;
                    len_d      = 8'd0;
                    s_addr_d   = 8'd0;
                    s_wrdata_d = 8'd0;
                    s_wren_d   = 1'b1;
                    state_d    = ST_INIT;
                end
            end
            ST_INIT: begin
                if (i_q == 8'hFF) begin
                    i_d      = 8'd0;
                    j_d      = 8'd0;
                    s_addr_d = 8'd0;
                    state_d  = ST_KSA_RI;
                end else begin
                    i_d        = i_q + 8'd1;
                    s_addr_d   = i_q + 8'd1;
                    s_wrdata_d = i_q + 8'd1;
                    s_wren_d   = 1'b1;
                end
            end
            ST_KSA_RI: state_d = ST_KSA_WI;
            ST_KSA_WI: begin
                si_d     = s_rddata;
                j_d      = w_ksa_j;
                s_addr_d = w_ksa_j;
                state_d  = ST_KSA_RJ;
            end
            ST_KSA_RJ: state_d = ST_KSA_WJ;
            ST_KSA_WJ: begin
                s_addr_d   = i_q;
                s_wrdata_d = s_rddata;
                s_wren_d   = 1'b1;
                state_d    = ST_KSA_SI;
            end
            ST_KSA_SI: begin
                s_addr_d   = j_q;
                s_wrdata_d = si_q;
                s_wren_d   = 1'b1;
                state_d    = ST_KSA_SJ;
            end
            ST_KSA_SJ: begin
                key_d = w_key_rot;
                if (i_q == 8'hFF) begin
                    pt_addr_d = 8'd0;
                    state_d   = ST_LEN_R;
                end else begin
                    i_d      = i_q + 8'd1;
                    s_addr_d = i_q + 8'd1;
                    state_d  = ST_KSA_RI;
                end
            end
            ST_LEN_R: state_d = ST_LEN_W;
            ST_LEN_W: begin
                len_d       = pt_rddata;
                ct_addr_d   = 8'd0;
                ct_wrdata_d = pt_rddata;
                ct_wren_d   = 1'b1;
                state_d     = ST_LEN_D;
            end
            ST_LEN_D: begin
                if (len_q == 8'd0) begin
                    state_d = ST_DONE;
                end else begin
                    i_d      = 8'd1;
                    j_d      = 8'd0;
                    k_d      = 8'd1;
                    s_addr_d = 8'd1;
                    state_d  = ST_PRGA_RI;
                end
            end
            ST_PRGA_RI: state_d = ST_PRGA_WI;
            ST_PRGA_WI: begin
                si_d     = s_rddata;
                j_d      = w_prga_j;
                s_addr_d = w_prga_j;
                state_d  = ST_PRGA_RJ;
            end
            ST_PRGA_RJ: state_d = ST_PRGA_WJ;
            ST_PRGA_WJ: begin
                sj_d       = s_rddata;
                s_addr_d   = i_q;
                s_wrdata_d = s_rddata;
                s_wren_d   = 1'b1;
                state_d    = ST_PRGA_SI;
            end
            ST_PRGA_SI: begin
                s_addr_d   = j_q;
                s_wrdata_d = si_q;
                s_wren_d   = 1'b1;
                state_d    = ST_PRGA_SJ;
            end
            ST_PRGA_SJ: begin
                // After the swap the two entries hold sj and si, so their sum is unchanged.
                s_addr_d  = si_q + sj_q;
                pt_addr_d = k_q;
                state_d   = ST_PRGA_RP;
            end
            ST_PRGA_RP: state_d = ST_PRGA_WP;
            ST_PRGA_WP: begin
                ct_addr_d   = k_q;
                ct_wrdata_d = pt_rddata ^ s_rddata;
                ct_wren_d   = 1'b1;
                state_d     = ST_PRGA_CT;
            end
            ST_PRGA_CT: begin
                if (k_q == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    k_d      = k_q + 8'd1;
                    i_d      = i_q + 8'd1;
                    s_addr_d = i_q + 8'd1;
                    state_d  = ST_PRGA_RI;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef ARC4_ENC_CYCLES_EN
    logic [19:0] cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_q <= 20'd0;
        end else if (rdy && en) begin
            cycles_q <= 20'd0;
        end else if (!rdy) begin
            cycles_q <= cycles_q + 20'd1;
        end
    end

    assign cycles = cycles_q;
`else
    // Cycle counter not built in this configuration.
`endif

endmodule

`default_nettype wire
